// File: rtl/cordic_arbiter.sv
`timescale 1ns/1ps
// cordic_arbiter: round-robin scheduler sharing one pipelined CORDIC
// datapath between several phase requesters. A tag pipe matched to the
// datapath latency routes each sine/cosine result back to its issuer.
// Optional build macro: CORDIC_ARB_FLUSH_EN adds a flush_i input that
// discards every in-flight request and blocks grants for that cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | nothing in flight, no grants
// ST_RUN   | grants allowed, results returned
// ST_DRAIN | no grants, waiting for in-flight results to return
module cordic_arbiter #(
    parameter int REQUESTERS  = 4,
    parameter int PHASE_WIDTH = 13,
    parameter int DATA_WIDTH  = 12,
    parameter int LATENCY     = 17
) (
    input  logic                              clock_i,
    input  logic                              reset_ni,
    input  logic                              enable_i,
`ifdef CORDIC_ARB_FLUSH_EN
    input  logic                              flush_i,
`endif
    input  logic [REQUESTERS-1:0]             req_valid_i,
    output logic [REQUESTERS-1:0]             req_ready_o,
    input  logic [REQUESTERS*PHASE_WIDTH-1:0] req_phase_i,
    input  logic [REQUESTERS*2-1:0]           req_quarter_i,
    output logic                              dp_valid_o,
    output logic [PHASE_WIDTH-1:0]            dp_phase_o,
    output logic [1:0]                        dp_quarter_o,
    input  logic [DATA_WIDTH:0]               dp_sine_i,
    input  logic [DATA_WIDTH:0]               dp_cosine_i,
    output logic [REQUESTERS-1:0]             rsp_valid_o,
    output logic [DATA_WIDTH:0]               rsp_sine_o,
    output logic [DATA_WIDTH:0]               rsp_cosine_o,
    output logic                              busy_o
);

    localparam int IDW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_en;
    logic   flush;

    logic [IDW-1:0]         ptr_q;
    logic [IDW-1:0]         cand;
    logic [IDW-1:0]         gnt_id;
    logic                   gnt_found;
    logic                   xfer;
    logic [PHASE_WIDTH-1:0] sel_phase;
    logic [1:0]             sel_quarter;

    logic                   dp_valid_q;
    logic [PHASE_WIDTH-1:0] dp_phase_q;
    logic [1:0]             dp_quarter_q;
    logic [IDW-1:0]         dp_id_q;

    logic [LATENCY-1:0]     tag_vld_q;
    logic [IDW-1:0]         tag_id_q [LATENCY];
    logic                   tag_out_vld;
    logic                   pipe_empty;

    logic [REQUESTERS-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH:0]    rsp_sine_q, rsp_cosine_q;

`ifdef CORDIC_ARB_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DRAIN only retires once dp stage and tag pipe are empty
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (enable_i) state_d = ST_RUN;
            ST_RUN:   if (!enable_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable_i) begin
                    state_d = ST_RUN;
                end else if (pipe_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        grant_en = (state_q == ST_RUN);
        busy_o   = (state_q != ST_IDLE);
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            cand = IDW'((int'(ptr_q) + k) % REQUESTERS);
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // Grant strobe; flush overrides any handshake in the same cycle
    always_comb begin
        req_ready_o = '0;
        if (gnt_found && grant_en && !flush) begin
            req_ready_o[gnt_id] = 1'b1;
        end
        xfer = |(req_valid_i & req_ready_o);
    end

    // Payload mux for the granted requester
    always_comb begin
        sel_phase   = '0;
        sel_quarter = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_phase   = req_phase_i[i*PHASE_WIDTH +: PHASE_WIDTH];
                sel_quarter = req_quarter_i[i*2 +: 2];
            end
        end
    end

    // Issue register and round-robin pointer; payload holds when idle
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dp_valid_q   <= 1'b0;
            dp_phase_q   <= '0;
            dp_quarter_q <= '0;
            dp_id_q      <= '0;
            ptr_q        <= IDW'(REQUESTERS - 1);
        end else begin
            dp_valid_q <= xfer;
            if (xfer) begin
                dp_phase_q   <= sel_phase;
                dp_quarter_q <= sel_quarter;
                dp_id_q      <= gnt_id;
                ptr_q        <= gnt_id;
            end
        end
    end

    assign dp_valid_o   = dp_valid_q;
    assign dp_phase_o   = dp_phase_q;
    assign dp_quarter_o = dp_quarter_q;

    // Tag pipe tracking the datapath latency; flush kills every valid bit
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tag_vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= dp_valid_q & ~flush;
            tag_id_q[0]  <= dp_id_q;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1] & ~flush;
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign tag_out_vld = tag_vld_q[LATENCY-1] & ~flush;
    assign pipe_empty  = ~(|tag_vld_q) & ~dp_valid_q;

    // Response strobe decode
    always_comb begin
        rsp_valid_d = '0;
        if (tag_out_vld) begin
            rsp_valid_d[tag_id_q[LATENCY-1]] = 1'b1;
        end
    end

    // Response register; result bus holds between responses
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rsp_valid_q  <= '0;
            rsp_sine_q   <= '0;
            rsp_cosine_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (tag_out_vld) begin
                rsp_sine_q   <= dp_sine_i;
                rsp_cosine_q <= dp_cosine_i;
            end
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_sine_o   = rsp_sine_q;
    assign rsp_cosine_o = rsp_cosine_q;

endmodule
